// File: rtl/circle_engine.sv
// Midpoint circle rasteriser: streams one outline or filled-disc pixel per clock
// to a VGA-style pixel writer, clipping anything outside the drawable area.
module circle_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                fill,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [R_W-1:0]      radius,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int XC = X_W + 2;
    localparam int YC = Y_W + 2;
    localparam int OW = R_W + 1;
    localparam int CW = R_W + 3;
    localparam logic signed [CW-1:0] CRIT_ONE = CW'(1);
    localparam logic signed [XC-1:0] SW_LIM   = XC'(SCREEN_W);
    localparam logic signed [YC-1:0] SH_LIM   = YC'(SCREEN_H);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_STEP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  fill_q, fill_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic [X_W-1:0]        cx_q, cx_d;
    logic [Y_W-1:0]        cy_q, cy_d;
    logic [R_W-1:0]        r_q, r_d;
    logic [OW-1:0]         ox_q, ox_d, oy_q, oy_d, cnt_q, cnt_d;
    logic signed [CW-1:0]  crit_q, crit_d;
    logic [2:0]            idx_q, idx_d;
    logic                  done_q, done_d, plot_q, plot_d;
    logic [X_W-1:0]        vx_q, vx_d;
    logic [Y_W-1:0]        vy_q, vy_d;
    logic [COLOUR_W-1:0]   vcol_q, vcol_d;

    logic [OW-1:0]         w_cur, oy_inc;
    logic                  span_end, iter_end, crit_pos, step_more;
    logic signed [CW-1:0]  oy_s, ox_s, crit_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fill_q   <= 1'b0;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            r_q      <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            cnt_q    <= '0;
            crit_q   <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            vx_q     <= '0;
            vy_q     <= '0;
            vcol_q   <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            colour_q <= colour_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            r_q      <= r_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            cnt_q    <= cnt_d;
            crit_q   <= crit_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            vcol_q   <= vcol_d;
        end
    end

    // Span/octant bookkeeping and the midpoint step, shared by both comb blocks.
    always_comb begin
        w_cur     = idx_q[1] ? oy_q : ox_q;
        span_end  = (cnt_q == (w_cur << 1));
        iter_end  = fill_q ? (span_end && idx_q == 3'd3) : (idx_q == 3'd7);
        oy_inc    = oy_q + OW'(1);
        crit_pos  = !crit_q[CW-1] && (crit_q != '0);
        oy_s      = CW'(oy_inc);
        ox_s      = CW'(ox_q) - (crit_pos ? CRIT_ONE : '0);
        crit_step = crit_pos ? crit_q + ((oy_s - ox_s) <<< 1) + CRIT_ONE
                             : crit_q + (oy_s <<< 1) + CRIT_ONE;
        step_more = (oy_s <= ox_s);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: state_d = S_PLOT;
            S_PLOT: if (iter_end) state_d = S_STEP;
            S_STEP: state_d = step_more ? S_PLOT : S_DONE;
            S_DONE: if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fill_d   = fill_q;
        colour_d = colour_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        r_d      = r_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        cnt_d    = cnt_q;
        crit_d   = crit_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: if (start) begin
                fill_d   = fill;
                colour_d = colour;
                cx_d     = centre_x;
                cy_d     = centre_y;
                r_d      = radius;
            end
            S_INIT: begin
                ox_d   = OW'(r_q);
                oy_d   = '0;
                crit_d = CRIT_ONE - CW'(r_q);
                idx_d  = '0;
                cnt_d  = '0;
            end
            S_PLOT: begin
                if (!fill_q) begin
                    idx_d = idx_q + 3'd1;
                end else if (span_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + OW'(1);
                end
            end
            S_STEP: begin
                oy_d   = oy_inc;
                ox_d   = ox_s[OW-1:0];
                crit_d = crit_step;
                idx_d  = '0;
                cnt_d  = '0;
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next-state view so vga_plot lines up with PLOT.
    logic signed [XC-1:0] cx_x, oxx, oyx, cntx, px;
    logic signed [YC-1:0] cy_y, oxy, oyy, py;
    logic                 on_screen;

    always_comb begin
        cx_x = XC'(cx_d);
        oxx  = XC'(ox_d);
        oyx  = XC'(oy_d);
        cntx = XC'(cnt_d);
        cy_y = YC'(cy_d);
        oxy  = YC'(ox_d);
        oyy  = YC'(oy_d);
        px   = cx_x;
        py   = cy_y;
        if (!fill_d) begin
            case (idx_d)
                3'd0: begin px = cx_x + oxx; py = cy_y + oyy; end
                3'd1: begin px = cx_x + oyx; py = cy_y + oxy; end
                3'd2: begin px = cx_x - oyx; py = cy_y + oxy; end
                3'd3: begin px = cx_x - oxx; py = cy_y + oyy; end
                3'd4: begin px = cx_x - oxx; py = cy_y - oyy; end
                3'd5: begin px = cx_x - oyx; py = cy_y - oxy; end
                3'd6: begin px = cx_x + oyx; py = cy_y - oxy; end
                default: begin px = cx_x + oxx; py = cy_y - oyy; end
            endcase
        end else begin
            px = cx_x - (idx_d[1] ? oyx : oxx) + cntx;
            case (idx_d[1:0])
                2'd0: py = cy_y + oyy;
                2'd1: py = cy_y - oyy;
                2'd2: py = cy_y + oxy;
                default: py = cy_y - oxy;
            endcase
        end
        on_screen = !px[XC-1] && (px < SW_LIM) && !py[YC-1] && (py < SH_LIM);

        done_d = (state_d == S_DONE);
        plot_d = (state_d == S_PLOT) && on_screen;
        vcol_d = colour_d;
        vx_d   = vx_q;
        vy_d   = vy_q;
        if (state_d == S_PLOT) begin
            vx_d = px[X_W-1:0];
            vy_d = py[Y_W-1:0];
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vcol_q;

endmodule

// File: tb/tb_circle_engine.sv
// Directed bench for circle_engine: default-size instance for draw, clip, handshake
// and reset cases, plus a 320x240 instance for right/bottom clipping.
module tb_circle_engine;

    logic       clk, rst;
    logic       start1, start2, fill;
    logic [2:0] colour;
    logic [8:0] cx;
    logic [7:0] cy;
    logic [7:0] radius;

    logic       done1, plot1, done2, plot2;
    logic [7:0] vx1;
    logic [6:0] vy1;
    logic [2:0] vc1, vc2;
    logic [8:0] vx2;
    logic [7:0] vy2;

    circle_engine u_dut (
        .clk(clk), .rst(rst), .start(start1), .fill(fill), .colour(colour),
        .centre_x(cx[7:0]), .centre_y(cy[6:0]), .radius(radius),
        .done(done1), .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .vga_plot(plot1)
    );

    circle_engine #(.SCREEN_W(320), .SCREEN_H(240), .X_W(9), .Y_W(8)) u_big (
        .clk(clk), .rst(rst), .start(start2), .fill(fill), .colour(colour),
        .centre_x(cx), .centre_y(cy), .radius(radius),
        .done(done2), .vga_x(vx2), .vga_y(vy2), .vga_colour(vc2), .vga_plot(plot2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- observation mux ----------------
    logic       sel;
    logic       o_done, o_plot;
    logic [8:0] o_x;
    logic [7:0] o_y;
    logic [2:0] o_col;
    assign o_done = sel ? done2 : done1;
    assign o_plot = sel ? plot2 : plot1;
    assign o_x    = sel ? vx2 : {1'b0, vx1};
    assign o_y    = sel ? vy2 : {1'b0, vy1};
    assign o_col  = sel ? vc2 : vc1;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_plot;
    int done_k;
    logic [31:0] first_px, second_px;
    bit saw_7_2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y);
        return {16'(x), 16'(y)};
    endfunction

    task automatic push_px(input int x, input int y, input int sw, input int sh);
        if (x >= 0 && x < sw && y >= 0 && y < sh) exp_q.push_back(pk(x, y));
    endtask

    // Reference rasteriser: fills exp_q with plotted pixels and returns the
    // number of clocks from the start edge until done is visible.
    task automatic model(input bit fl, input int x0, input int y0, input int r,
                         input int sw, input int sh, output int cyc);
        int ox, oy, crit;
        exp_q.delete();
        cyc  = 1;
        ox   = r;
        oy   = 0;
        crit = 1 - r;
        forever begin
            if (!fl) begin
                push_px(x0 + ox, y0 + oy, sw, sh);
                push_px(x0 + oy, y0 + ox, sw, sh);
                push_px(x0 - oy, y0 + ox, sw, sh);
                push_px(x0 - ox, y0 + oy, sw, sh);
                push_px(x0 - ox, y0 - oy, sw, sh);
                push_px(x0 - oy, y0 - ox, sw, sh);
                push_px(x0 + oy, y0 - ox, sw, sh);
                push_px(x0 + ox, y0 - oy, sw, sh);
                cyc += 8;
            end else begin
                for (int xx = x0 - ox; xx <= x0 + ox; xx++) push_px(xx, y0 + oy, sw, sh);
                for (int xx = x0 - ox; xx <= x0 + ox; xx++) push_px(xx, y0 - oy, sw, sh);
                for (int xx = x0 - oy; xx <= x0 + oy; xx++) push_px(xx, y0 + ox, sw, sh);
                for (int xx = x0 - oy; xx <= x0 + oy; xx++) push_px(xx, y0 - ox, sw, sh);
                cyc += 4 * (2 * ox + 1) + 0;
                cyc += 0;
                cyc -= 2 * (2 * ox + 1);
                cyc += 2 * (2 * oy + 1);
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
            cyc++;
            if (oy > ox) break;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_draw(input bit s, input bit fl, input logic [2:0] col,
                            input int x0, input int y0, input int r, input bit hold,
                            input string tag);
        int  exp_cyc;
        bit  got_done;
        int  dx, dy;
        sel = s;
        model(fl, x0, y0, r, s ? 320 : 160, s ? 240 : 120, exp_cyc);
        n_plot   = 0;
        saw_7_2  = 0;
        done_k   = -1;
        first_px = '1;
        second_px = '1;
        @(negedge clk);
        fill   = fl;
        colour = col;
        cx     = 9'(x0);
        cy     = 8'(y0);
        radius = 8'(r);
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            start1 = 1'b0;
            start2 = 1'b0;
        end
        // Scrambled inputs must not disturb a draw already in progress.
        fill   = ~fl;
        colour = ~col;
        cx     = 9'd3;
        cy     = 8'd4;
        radius = 8'd40;
        got_done = 0;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            if (k > 0) @(negedge clk);
            if (o_plot) begin
                n_plot++;
                if (n_plot == 1) first_px = pk(int'(o_x), int'(o_y));
                if (n_plot == 2) second_px = pk(int'(o_x), int'(o_y));
                if (o_x == 9'd7 && o_y == 8'd2) saw_7_2 = 1;
                check_eq({tag, "_colour"}, 32'(o_col), 32'(col));
                if (exp_q.size() == 0) check_eq({tag, "_extra_px"}, pk(int'(o_x), int'(o_y)), 32'hFFFF_FFFF);
                else check_eq({tag, "_px"}, pk(int'(o_x), int'(o_y)), exp_q.pop_front());
                if (fl) begin
                    dx = int'(o_x) - x0;
                    dy = int'(o_y) - y0;
                    check_eq({tag, "_in_disc"}, 32'(4*dx*dx + 4*dy*dy <= (2*r+1)*(2*r+1)), 32'd1);
                end
            end
            if (o_done) begin
                got_done = 1;
                done_k   = k;
                check_eq({tag, "_done_cycle"}, 32'(k), 32'(exp_cyc));
            end
        end
        if (!got_done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        check_eq({tag, "_missing_px"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int pulses;

    initial begin
        rst = 1'b1; start1 = 0; start2 = 0; fill = 0; colour = 0;
        cx = 0; cy = 0; radius = 0; sel = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_done", 32'(done1), 32'd0);
        check_eq("rst_plot", 32'(plot1), 32'd0);
        check_eq("rst_xy", {16'(vx1), 16'(vy1)}, 32'd0);
        check_eq("rst_colour", 32'(vc1), 32'd0);
        check_eq("rst_big", {16'(vx2), 8'(vy2), 5'(vc2), 1'b0, done2, plot2}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_done", 32'(done1), 32'd0);

        // Outline r=3: 24 pulses, done at E0+28.
        run_draw(0, 0, 3'd5, 80, 60, 3, 0, "outline");
        check_eq("outline_count", 32'(n_plot), 32'd24);
        check_eq("outline_first", first_px, pk(83, 60));
        check_eq("outline_second", second_px, pk(80, 63));
        check_eq("outline_latency", 32'(done_k), 32'd28);
        @(negedge clk);
        check_eq("outline_done_drop", 32'(done1), 32'd0);

        // Filled disc r=3: 56 plot cycles all on-screen.
        run_draw(0, 1, 3'd2, 80, 60, 3, 0, "fill");
        check_eq("fill_count", 32'(n_plot), 32'd56);
        check_eq("fill_first", first_px, pk(77, 60));
        check_eq("fill_latency", 32'(done_k), 32'd60);

        // Clipping against left/top edges.
        run_draw(0, 0, 3'd7, 2, 2, 5, 0, "clip");
        check_eq("clip_saw_7_2", 32'(saw_7_2), 32'd1);
        check_eq("clip_done_seen", 32'(done_k >= 0), 32'd1);

        // Zero radius.
        run_draw(0, 0, 3'd1, 10, 10, 0, 0, "r0_outline");
        check_eq("r0_outline_count", 32'(n_plot), 32'd8);
        check_eq("r0_outline_px", first_px, pk(10, 10));
        run_draw(0, 1, 3'd4, 10, 10, 0, 0, "r0_fill");
        check_eq("r0_fill_count", 32'(n_plot), 32'd4);

        // Handshake: start held through DONE.
        run_draw(0, 0, 3'd6, 80, 60, 3, 1, "hold");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("hold_done", 32'(done1), 32'd1);
            check_eq("hold_no_plot", 32'(plot1), 32'd0);
        end
        start1 = 1'b0;
        @(negedge clk);
        check_eq("hold_release_done", 32'(done1), 32'd0);
        run_draw(0, 0, 3'd3, 80, 60, 3, 0, "redraw");
        check_eq("redraw_first", first_px, pk(83, 60));
        check_eq("redraw_count", 32'(n_plot), 32'd24);

        // Asynchronous reset at the 10th pixel.
        sel = 0;
        @(negedge clk);
        fill = 0; colour = 3'd5; cx = 9'd80; cy = 8'd60; radius = 8'd3; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 200 && pulses < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (plot1) pulses++;
        end
        check_eq("midrst_reached_10", 32'(pulses), 32'd10);
        rst = 1'b1;
        #1;
        check_eq("midrst_plot", 32'(plot1), 32'd0);
        check_eq("midrst_done", 32'(done1), 32'd0);
        check_eq("midrst_xy", {16'(vx1), 16'(vy1)}, 32'd0);
        check_eq("midrst_colour", 32'(vc1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", {16'(vx1), 8'(vy1), 5'(vc1), 1'b0, done1, plot1}, 32'd0);
        end

        // Wider screen: clipping at the right and bottom edges.
        run_draw(1, 0, 3'd6, 300, 230, 15, 0, "big");
        check_eq("big_first", first_px, pk(315, 230));
        check_eq("big_plotted_some", 32'(n_plot > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/circle_engine.md
CIRCLE_ENGINE -- requirements
Module: circle_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning drawable width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning drawable height in pixels.
REQ-003 SHALL have parameter X_W, default 8, meaning x coordinate width.
REQ-004 SHALL have parameter Y_W, default 7, meaning y coordinate width.
REQ-005 SHALL have parameter R_W, default 8, meaning radius width.
REQ-006 SHALL have parameter COLOUR_W, default 3, meaning colour width.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-009 SHALL have port start, input, 1, meaning request to draw.
REQ-010 SHALL have port fill, input, 1, meaning 0 = outline, 1 = filled disc.
REQ-011 SHALL have port colour, input, COLOUR_W, meaning draw colour.
REQ-012 SHALL have port centre_x, input, X_W, meaning centre x.
REQ-013 SHALL have port centre_y, input, Y_W, meaning centre y.
REQ-014 SHALL have port radius, input, R_W, meaning radius.
REQ-015 SHALL have port done, output, 1, meaning draw complete.
REQ-016 SHALL have port vga_x, output, X_W, meaning pixel x.
REQ-017 SHALL have port vga_y, output, Y_W, meaning pixel y.
REQ-018 SHALL have port vga_colour, output, COLOUR_W, meaning pixel colour.
REQ-019 SHALL have port vga_plot, output, 1, meaning write-enable for the current pixel.

Function
REQ-020 SHALL implement states IDLE, INIT, PLOT, STEP and DONE; all outputs SHALL be registered.
REQ-021 In IDLE, start=1 SHALL move to INIT and latch colour, fill, centre and radius; input changes after that SHALL be ignored until the next draw.
REQ-022 INIT SHALL set oy=0, ox=radius, crit=1-radius, with crit signed R_W+3 bits, then go to PLOT.
REQ-023 PLOT, outline mode, SHALL emit exactly 8 pixels per iteration, one per clock, in octant order: (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-oy,cy+ox), (cx-ox,cy+oy), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+oy,cy-ox), (cx+ox,cy-oy).
REQ-024 PLOT, filled mode, SHALL emit left-to-right horizontal spans, one pixel per clock: row cy+oy over x=cx-ox..cx+ox, then row cy-oy over the same x range, then row cy+ox over x=cx-oy..cx+oy, then row cy-ox over the same x range; overdraw of duplicate pixels is permitted.
REQ-025 STEP (1 clock) SHALL do oy+=1, then: if crit<=0, crit+=2*oy+1; otherwise ox-=1 and crit+=2*(oy-ox)+1; next state SHALL be PLOT if oy<=ox, else DONE.
REQ-026 Coordinates SHALL be computed signed in X_W+2 / Y_W+2 bits; vga_plot SHALL be 1 only in PLOT and only when 0<=x<SCREEN_W and 0<=y<SCREEN_H; off-screen pixels SHALL consume their cycle with vga_plot=0 and vga_x/vga_y driven with the truncated values.
REQ-027 vga_colour SHALL equal the latched colour throughout a draw.
REQ-028 DONE SHALL drive done=1 and SHALL hold it while start=1; start=0 SHALL return to IDLE with done=0 on the next edge; a start held high through DONE SHALL NOT retrigger a draw.
REQ-029 radius=0 SHALL complete one iteration at (cx,cy): 8 identical pixels in outline mode, 4 in filled mode.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, including mid-draw; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 Outline, centre (80,60), r=3: start accepted at edge E0 -> 24 vga_plot pulses; first pulse at (83,60), second at (80,63); done rises at E0+28.
REQ-032 Filled, centre (80,60), r=3 -> 56 PLOT cycles, every pixel within distance <=3.5 of centre, no plotted pixel missing from any row 57..63.
REQ-033 Clipping, centre (2,2), r=5, outline -> vga_plot never 1 with x<0 or y<0; pixel (7,2) plotted; done still asserted.
REQ-034 Handshake: hold start=1 past done -> done stays 1 with no new pixels; start=0 -> done=0 next edge; start=1 -> new draw whose first pixel matches REQ-031.
REQ-035 Reset mid-draw: assert rst at the 10th pixel -> vga_plot=0 and done=0 without waiting for a clock; after release, no output activity until start.
REQ-036 Parameters SCREEN_W=320, SCREEN_H=240, X_W=9, Y_W=8, centre (300,230), r=15 -> pixels with x>=320 or y>=240 are suppressed; pixels in range are plotted.
